exec_writeback: RTL and testbench
=================================

// Module: exec_writeback
// PURPOSE
//  Consumer end of the decode-stage output bundle: takes IR/PC/DATA1..3, executes the ALU op, and drives
//  the register-file write port (WE/WADDR/WDATA), closing the loop decode opens with its read ports.
//  Also issues jump redirects with an upstream flush window and publishes pending destinations for hazard checks.
// PARAMETERS
//  WIDTH         16  datapath / IR / PC width
//  RADDR_W       4   register address width (16 registers, R0 hardwired zero)
//  FLUSH_CYCLES  2   cycles FLUSH stays high after a jump redirect (legal range 1..7)
// PORTS
//  CLK        in   1        clock, all state on posedge
//  RST_N      in   1        asynchronous active-low reset
//  VALIDIN    in   1        decode bundle valid
//  READYOUT   out  1        bundle accepted on posedge when VALIDIN & READYOUT
//  IRIN       in   WIDTH    instruction; op=[15:12], target=[7:0]
//  PCIN       in   WIDTH    instruction PC
//  DATAIN1    in   WIDTH    [3:0] dest register (R-type/ADDI); [7:0] jump target (JUMP)
//  DATAIN2    in   WIDTH    operand A (R-type) / zero-extended immediate (ADDI)
//  DATAIN3    in   WIDTH    operand B (R-type) / ADDI base operand
//  STALL      in   1        freezes every register in this block
//  WE         out  1        register-file write enable
//  WADDR      out  RADDR_W  write address
//  WDATA      out  WIDTH    write data
//  REDIRECT   out  1        one-cycle pulse: fetch loads TARGET
//  TARGET     out  WIDTH    {8'h00, target}
//  FLUSH      out  1        upstream must squash fetch/decode contents
//  PENDEX     out  1        EX slot holds a register write;  PENDEXREG out RADDR_W its destination
//  PENDWB     out  1        WB slot holds a register write;  PENDWBREG out RADDR_W its destination
//  INSTRET    out  WIDTH    count of retired instructions
// BEHAVIOUR
//  - Reset (async, RST_N low): EX/WB valid=0, WE=0, WADDR=0, WDATA=0, REDIRECT=0, TARGET=0, FLUSH=0,
//    PENDEX/PENDWB=0, regs=0, INSTRET=0, FSM=RUN. Reset mid-flush or mid-write drops everything in flight.
//  - READYOUT = !STALL && state==RUN. Combinational, no bubble insertion on its own.
//  - Pipeline: accept at edge N -> EX slot (ALU result) valid cycle N..N+1 -> WB slot at edge N+1 ->
//    WE/WADDR/WDATA high whole cycle N+1..N+2 -> register file captures at edge N+2. Throughput 1/cycle.
//  - Ops: ADD A+B, SUB A-B, AND, OR: mod 2^WIDTH, carry/borrow discarded. SLT: signed A<B -> 1 else 0.
//    ADDI: DATAIN2+DATAIN3 mod 2^WIDTH. Destination = DATAIN1[3:0].
//  - Dest R0: result computed, PEND* and WE stay 0 (R0 never written). Unknown/zero op = NOP: retires, no write.
//  - JUMP: no write. On the edge it enters EX: REDIRECT=1, TARGET loaded, FLUSH=1, FSM RUN->FLUSH,
//    counter=FLUSH_CYCLES-1. Each unstalled edge in FLUSH decrements; at 0 -> RUN, FLUSH=0 same edge.
//    REDIRECT deasserts next unstalled edge. Bundles presented during FLUSH are not accepted.
//  - STALL=1: no acceptance, EX/WB/FSM/counter/INSTRET hold; WE held high if WB valid, register file must
//    tolerate the repeated identical write. REDIRECT stays high while stalled (pulse stretched).
//  - INSTRET increments once per instruction leaving WB (including NOPs/JUMP/R0 writes), wraps at 2^WIDTH.
//  - PENDEX/PENDWB reflect slot contents combinationally from registers; decode compares against its
//    read addresses. No internal forwarding: back-to-back dependents are decode's responsibility.
// STRUCTURE
//  - Shared defines header: opcode constants (`ADD,`SUB,`AND,`OR,`SLT,`ADDI,`JUMP), field slices
//    (`GET_OP,`GET_TARGET), ZERO constant; same header decode already uses.
//  - Sub-module alu16: combinational (op, A, B) -> result; FSM, EX/WB registers, counters stay here.
// TESTING
//  1 Reset: hold RST_N=0 mid-stream with WB valid -> all outputs 0 immediately, no WE after release.
//  2 ADD dest R3, A=16'hFFFF, B=16'h0002 -> 2 cycles later WE=1, WADDR=3, WDATA=16'h0001; INSTRET+1.
//  3 SLT A=16'h8000, B=16'h0001 -> WDATA=1; swapped -> WDATA=0; ADD dest R0 -> WE never high.
//  4 JUMP target 8'h42, then two more bundles -> REDIRECT 1 cycle, TARGET=16'h0042, FLUSH 2 cycles,
//    READYOUT=0 during FLUSH, following bundles not accepted.
//  5 STALL high 3 cycles with ADDI in WB -> WE/WADDR/WDATA/INSTRET frozen; resumes correctly on release.
//  6 Back-to-back ADD R1, SUB R2 -> PENDEX/PENDWB show 1 then 2 in order; writes land on consecutive edges.

Source files
------------

// File: rtl/exec_writeback_pkg.sv
// Shared opcode encoding, instruction field geometry and FSM state type
// for the execute/writeback stage.
package exec_writeback_pkg;

  localparam int OP_W  = 4;
  localparam int TGT_W = 8;
  localparam int CNT_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_SLT  = 4'h5,
    OP_ADDI = 4'h6,
    OP_JUMP = 4'h7
  } op_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } fsm_t;

  // Ops that produce a register-file write (R0 filtering happens at the call site).
  function automatic logic op_writes(op_t op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_ADDI: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/exec_writeback_alu16.sv
// Combinational ALU: (op, a, b) -> result, arithmetic modulo 2^WIDTH.
module exec_writeback_alu16
  import exec_writeback_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_ADDI: result = a + b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/exec_writeback.sv
// Execute/writeback stage: runs the ALU on accepted decode bundles, drives the
// register-file write port and issues jump redirects with an upstream flush window.
module exec_writeback
  import exec_writeback_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int RADDR_W      = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               VALIDIN,
  output logic               READYOUT,
  input  logic [WIDTH-1:0]   IRIN,
  input  logic [WIDTH-1:0]   PCIN,
  input  logic [WIDTH-1:0]   DATAIN1,
  input  logic [WIDTH-1:0]   DATAIN2,
  input  logic [WIDTH-1:0]   DATAIN3,
  input  logic               STALL,
  output logic               WE,
  output logic [RADDR_W-1:0] WADDR,
  output logic [WIDTH-1:0]   WDATA,
  output logic               REDIRECT,
  output logic [WIDTH-1:0]   TARGET,
  output logic               FLUSH,
  output logic               PENDEX,
  output logic [RADDR_W-1:0] PENDEXREG,
  output logic               PENDWB,
  output logic [RADDR_W-1:0] PENDWBREG,
  output logic [WIDTH-1:0]   INSTRET
);

  localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_CYCLES - 1);

  op_t                op;
  logic [RADDR_W-1:0] dest_in;
  logic               accept;
  logic               wr_in;
  logic               jump_in;
  logic [WIDTH-1:0]   alu_result;

  fsm_t               state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               redirect_reg, redirect_next;
  logic [WIDTH-1:0]   target_reg, target_next;

  logic               ex_valid_reg;
  logic               ex_wr_reg;
  logic [RADDR_W-1:0] ex_dest_reg;
  logic [WIDTH-1:0]   ex_result_reg;
  logic               wb_valid_reg;
  logic               we_reg;
  logic [RADDR_W-1:0] waddr_reg;
  logic [WIDTH-1:0]   wdata_reg;
  logic [WIDTH-1:0]   instret_reg;

  // PC, spare IR bits and the upper DATAIN1 bits carry nothing this stage needs.
  logic unused_inputs;
  assign unused_inputs = ^{PCIN, IRIN[WIDTH-OP_W-1:TGT_W], DATAIN1[WIDTH-1:RADDR_W]};

  assign op       = op_t'(IRIN[WIDTH-1 -: OP_W]);
  assign dest_in  = DATAIN1[RADDR_W-1:0];
  assign READYOUT = !STALL && (state_reg == ST_RUN);
  assign accept   = VALIDIN && READYOUT;
  assign wr_in    = op_writes(op) && (dest_in != '0);
  assign jump_in  = accept && (op == OP_JUMP);

  exec_writeback_alu16 #(
    .WIDTH (WIDTH)
  ) u_alu (
    .op     (op),
    .a      (DATAIN2),
    .b      (DATAIN3),
    .result (alu_result)
  );

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    redirect_next = redirect_reg;
    target_next   = target_reg;
    if (!STALL) begin
      redirect_next = 1'b0;
      case (state_reg)
        ST_RUN: begin
          if (jump_in) begin
            state_next    = ST_FLUSH;
            cnt_next      = FLUSH_INIT;
            redirect_next = 1'b1;
            target_next   = {{(WIDTH-TGT_W){1'b0}}, IRIN[TGT_W-1:0]};
          end
        end
        ST_FLUSH: begin
          if (cnt_reg == '0) state_next = ST_RUN;
          else               cnt_next   = cnt_reg - 1'b1;
        end
        default: state_next = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg    <= ST_RUN;
      cnt_reg      <= '0;
      redirect_reg <= 1'b0;
      target_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      redirect_reg <= redirect_next;
      target_reg   <= target_next;
    end
  end

  // EX -> WB pipeline; a stall freezes both slots and the retire counter.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ex_valid_reg  <= 1'b0;
      ex_wr_reg     <= 1'b0;
      ex_dest_reg   <= '0;
      ex_result_reg <= '0;
      wb_valid_reg  <= 1'b0;
      we_reg        <= 1'b0;
      waddr_reg     <= '0;
      wdata_reg     <= '0;
      instret_reg   <= '0;
    end else if (!STALL) begin
      ex_valid_reg  <= accept;
      ex_wr_reg     <= accept && wr_in;
      ex_dest_reg   <= dest_in;
      ex_result_reg <= alu_result;
      wb_valid_reg  <= ex_valid_reg;
      we_reg        <= ex_wr_reg;
      waddr_reg     <= ex_dest_reg;
      wdata_reg     <= ex_result_reg;
      if (wb_valid_reg) instret_reg <= instret_reg + 1'b1;
    end
  end

  assign WE        = we_reg;
  assign WADDR     = waddr_reg;
  assign WDATA     = wdata_reg;
  assign REDIRECT  = redirect_reg;
  assign TARGET    = target_reg;
  assign FLUSH     = (state_reg == ST_FLUSH);
  assign PENDEX    = ex_wr_reg;
  assign PENDEXREG = ex_dest_reg;
  assign PENDWB    = we_reg;
  assign PENDWBREG = waddr_reg;
  assign INSTRET   = instret_reg;

endmodule

// File: tb/tb_exec_writeback.sv
// Self-checking bench for exec_writeback: directed vector table, hand-written
// corner sequences and randomized traffic against a transaction-level model.
module tb_exec_writeback;

  localparam int FC = 2;
  localparam logic [3:0] T_NOP = 4'h0, T_ADD = 4'h1, T_SUB = 4'h2, T_AND = 4'h3,
                         T_OR  = 4'h4, T_SLT = 4'h5, T_ADDI = 4'h6, T_JUMP = 4'h7;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        VALIDIN;
  logic        READYOUT;
  logic [15:0] IRIN, PCIN, DATAIN1, DATAIN2, DATAIN3;
  logic        STALL;
  logic        WE;
  logic [3:0]  WADDR;
  logic [15:0] WDATA;
  logic        REDIRECT;
  logic [15:0] TARGET;
  logic        FLUSH;
  logic        PENDEX;
  logic [3:0]  PENDEXREG;
  logic        PENDWB;
  logic [3:0]  PENDWBREG;
  logic [15:0] INSTRET;

  exec_writeback #(.WIDTH(16), .RADDR_W(4), .FLUSH_CYCLES(FC)) dut (
    .CLK(CLK), .RST_N(RST_N), .VALIDIN(VALIDIN), .READYOUT(READYOUT),
    .IRIN(IRIN), .PCIN(PCIN), .DATAIN1(DATAIN1), .DATAIN2(DATAIN2), .DATAIN3(DATAIN3),
    .STALL(STALL), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
    .REDIRECT(REDIRECT), .TARGET(TARGET), .FLUSH(FLUSH),
    .PENDEX(PENDEX), .PENDEXREG(PENDEXREG), .PENDWB(PENDWB), .PENDWBREG(PENDWBREG),
    .INSTRET(INSTRET)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  // Model: instruction accepted at advance index k sits in EX after edge k,
  // in WB after edge k+1, and retires on edge k+2.
  typedef struct {
    logic        valid;
    logic        writes;
    logic [3:0]  dest;
    logic [15:0] result;
  } slot_t;

  slot_t       slots [0:4095];
  int          cyc;
  int          last_jump;
  int          retired;
  logic [15:0] tgt_exp;
  logic [15:0] pc_cnt;

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  dest;
    logic [15:0] a;
    logic [15:0] b;
    logic        exp_we;
    logic [15:0] exp_wdata;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (adv %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  function automatic logic [15:0] ref_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      T_ADD, T_ADDI: return a + b;
      T_SUB:         return a - b;
      T_AND:         return a & b;
      T_OR:          return a | b;
      T_SLT:         return (sa < sb) ? 16'd1 : 16'd0;
      default:       return 16'd0;
    endcase
  endfunction

  function automatic logic ref_writes(input logic [3:0] op, input logic [3:0] dest);
    return (op >= T_ADD) && (op <= T_ADDI) && (dest != 4'd0);
  endfunction

  function automatic logic m_flush();
    return (cyc >= last_jump) && (cyc < last_jump + FC);
  endfunction

  task automatic model_reset();
    cyc       = 0;
    last_jump = -100;
    retired   = 0;
    tgt_exp   = 16'h0000;
    slots[0]  = '{valid: 1'b0, writes: 1'b0, dest: 4'd0, result: 16'd0};
  endtask

  task automatic check_outputs();
    slot_t wb, ex;
    logic  exp_we;
    wb = (cyc >= 1) ? slots[cyc-1] : '{valid: 1'b0, writes: 1'b0, dest: 4'd0, result: 16'd0};
    ex = slots[cyc];
    exp_we = wb.valid && wb.writes;
    chk("we", WE, exp_we);
    chk("pendwb", PENDWB, exp_we);
    if (exp_we) begin
      chk("waddr", WADDR, wb.dest);
      chk("wdata", WDATA, wb.result);
      chk("pendwbreg", PENDWBREG, wb.dest);
    end
    chk("pendex", PENDEX, ex.valid && ex.writes);
    if (ex.valid && ex.writes) chk("pendexreg", PENDEXREG, ex.dest);
    chk("instret", INSTRET, retired[15:0]);
    chk("redirect", REDIRECT, cyc == last_jump);
    chk("flush", FLUSH, m_flush());
    chk("target", TARGET, tgt_exp);
  endtask

  // One clock: drive a bundle, check READYOUT, advance the model, check outputs.
  task automatic step(input logic st, input logic v, input logic [15:0] ir,
                      input logic [15:0] d1, input logic [15:0] d2, input logic [15:0] d3);
    logic       exp_ready;
    logic [3:0] op;
    @(negedge CLK);
    STALL   = st;
    VALIDIN = v;
    IRIN    = ir;
    PCIN    = pc_cnt;
    DATAIN1 = d1;
    DATAIN2 = d2;
    DATAIN3 = d3;
    #1;
    exp_ready = !st && !m_flush();
    chk("readyout", READYOUT, exp_ready);
    @(posedge CLK);
    if (!st) begin
      cyc++;
      slots[cyc] = '{valid: 1'b0, writes: 1'b0, dest: 4'd0, result: 16'd0};
      if (v && exp_ready) begin
        op = ir[15:12];
        slots[cyc] = '{valid: 1'b1, writes: ref_writes(op, d1[3:0]), dest: d1[3:0],
                       result: ref_alu(op, d2, d3)};
        if (op == T_JUMP) begin
          last_jump = cyc;
          tgt_exp   = {8'h00, ir[7:0]};
        end
        pc_cnt = pc_cnt + 16'd1;
        $display("[TB] adv %0d accept op=%0h d1=%h a=%h b=%h", cyc, op, d1, d2, d3);
      end
      if (cyc >= 2 && slots[cyc-2].valid) retired++;
    end
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " we"}, WE, 1'b0);
    chk({tag, " waddr"}, WADDR, 4'd0);
    chk({tag, " wdata"}, WDATA, 16'd0);
    chk({tag, " redirect"}, REDIRECT, 1'b0);
    chk({tag, " target"}, TARGET, 16'd0);
    chk({tag, " flush"}, FLUSH, 1'b0);
    chk({tag, " pendex"}, PENDEX, 1'b0);
    chk({tag, " pendwb"}, PENDWB, 1'b0);
    chk({tag, " instret"}, INSTRET, 16'd0);
  endtask

  initial begin
    logic [15:0] saved_instret;
    logic        st, v;
    logic [3:0]  op, dest;
    logic [7:0]  tgt;

    vecs[0] = '{T_ADD,  4'd3, 16'hFFFF, 16'h0002, 1'b1, 16'h0001};
    vecs[1] = '{T_SLT,  4'd4, 16'h8000, 16'h0001, 1'b1, 16'h0001};
    vecs[2] = '{T_SLT,  4'd4, 16'h0001, 16'h8000, 1'b1, 16'h0000};
    vecs[3] = '{T_ADD,  4'd0, 16'h1234, 16'h1111, 1'b0, 16'h0000};
    vecs[4] = '{T_SUB,  4'd2, 16'h0003, 16'h0005, 1'b1, 16'hFFFE};
    vecs[5] = '{T_AND,  4'd7, 16'hF0F0, 16'h3C3C, 1'b1, 16'h3030};
    vecs[6] = '{T_OR,   4'd8, 16'hF0F0, 16'h0F01, 1'b1, 16'hFFF1};
    vecs[7] = '{T_ADDI, 4'd5, 16'h0010, 16'h0FF0, 1'b1, 16'h1000};
    vecs[8] = '{T_NOP,  4'd9, 16'h1111, 16'h2222, 1'b0, 16'h0000};
    vecs[9] = '{4'hE,   4'd9, 16'h1111, 16'h2222, 1'b0, 16'h0000};

    RST_N = 1'b0; VALIDIN = 1'b0; STALL = 1'b0;
    IRIN = '0; PCIN = '0; DATAIN1 = '0; DATAIN2 = '0; DATAIN3 = '0;
    pc_cnt = 16'h0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1 check_all_zero("reset");
    @(negedge CLK);
    RST_N = 1'b1;

    // Directed vector table: each bundle alone, checked when it reaches WB.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, {vecs[i].op, 12'h000}, {12'h000, vecs[i].dest}, vecs[i].a, vecs[i].b);
      step(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
      chk($sformatf("vec%0d we", i), WE, vecs[i].exp_we);
      if (vecs[i].exp_we) begin
        chk($sformatf("vec%0d waddr", i), WADDR, vecs[i].dest);
        chk($sformatf("vec%0d wdata", i), WDATA, vecs[i].exp_wdata);
      end
    end
    idle(2);
    chk("table instret", INSTRET, 16'd10);

    // Back-to-back ADD R1, SUB R2: pending destinations and consecutive writes.
    step(1'b0, 1'b1, {T_ADD, 12'h0}, 16'h0001, 16'h0005, 16'h0006);
    chk("b2b pendexreg1", PENDEXREG, 4'd1);
    step(1'b0, 1'b1, {T_SUB, 12'h0}, 16'h0002, 16'h0003, 16'h0001);
    chk("b2b pendexreg2", PENDEXREG, 4'd2);
    chk("b2b pendwbreg1", PENDWBREG, 4'd1);
    chk("b2b wdata1", WDATA, 16'd11);
    step(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    chk("b2b waddr2", WADDR, 4'd2);
    chk("b2b wdata2", WDATA, 16'd2);
    idle(2);

    // JUMP to 0x42 followed by two bundles that must be refused.
    step(1'b0, 1'b1, {T_JUMP, 4'h0, 8'h42}, 16'h0042, 16'h0, 16'h0);
    chk("jump redirect", REDIRECT, 1'b1);
    chk("jump target", TARGET, 16'h0042);
    chk("jump flush0", FLUSH, 1'b1);
    step(1'b0, 1'b1, {T_ADD, 12'h0}, 16'h000A, 16'h0001, 16'h0001);
    chk("jump redirect off", REDIRECT, 1'b0);
    chk("jump flush1", FLUSH, 1'b1);
    step(1'b0, 1'b1, {T_ADD, 12'h0}, 16'h000B, 16'h0001, 16'h0001);
    chk("jump flush2", FLUSH, 1'b0);
    idle(3);

    // ADDI in WB held across a 3-cycle stall.
    step(1'b0, 1'b1, {T_ADDI, 12'h0}, 16'h0006, 16'h0005, 16'h1234);
    step(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    saved_instret = INSTRET;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, {T_ADD, 12'h0}, 16'h000C, 16'h0001, 16'h0001);
      chk("stall we", WE, 1'b1);
      chk("stall waddr", WADDR, 4'd6);
      chk("stall wdata", WDATA, 16'h1239);
      chk("stall instret", INSTRET, saved_instret);
    end
    step(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    chk("unstall we", WE, 1'b0);
    chk("unstall instret", INSTRET, saved_instret + 16'd1);
    idle(2);

    // Asynchronous reset with a write in WB and a flush in progress.
    step(1'b0, 1'b1, {T_ADD, 12'h0}, 16'h0004, 16'h0001, 16'h0002);
    step(1'b0, 1'b1, {T_JUMP, 4'h0, 8'h17}, 16'h0017, 16'h0, 16'h0);
    chk("pre-reset we", WE, 1'b1);
    VALIDIN = 1'b0;
    #2 RST_N = 1'b0;
    #1 check_all_zero("async reset");
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    model_reset();
    idle(3);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      st   = ($urandom_range(0, 9) < 2);
      v    = ($urandom_range(0, 9) < 7);
      op   = 4'($urandom_range(0, 8));
      if (op == 4'd8) op = 4'($urandom_range(8, 15));
      dest = 4'($urandom_range(0, 15));
      tgt  = 8'($urandom_range(0, 255));
      step(st, v, {op, 4'($urandom_range(0, 15)), tgt},
           (op == T_JUMP) ? {8'h00, tgt} : {12'($urandom_range(0, 4095)), dest},
           16'($urandom), 16'($urandom));
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
